// File: rtl/common.sv
// Shared scalar types used across the core.
package common;
  typedef logic [63:0] u64;
  typedef logic [7:0]  u8;
  typedef logic [2:0]  u3;
endpackage

// File: rtl/decode_pkg.sv
// Decode-stage types shared with the memory stage.
package decode_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;
endpackage

// File: rtl/mem_ctrl_pkg.sv
// Memory-stage controller states, lane-strobe constants and the strobe generator.
package mem_ctrl_pkg;
  import common::*;
  import decode_pkg::*;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} mctrl_state_t;

  localparam u8 STRB_B = 8'h01;
  localparam u8 STRB_H = 8'h03;
  localparam u8 STRB_W = 8'h0F;
  localparam u8 STRB_D = 8'hFF;

  // The 8-bit shift drops lanes past byte 7 rather than wrapping them.
  function automatic u8 strobe_gen(msize_t size, u3 a);
    u8 s;
    case (size)
      MSIZE1:  s = STRB_B << a;
      MSIZE2:  s = STRB_H << a;
      MSIZE4:  s = STRB_W << a;
      default: s = STRB_D;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// Combinational byte-lane shifter for stores plus misalignment detect.
// Misalign detect is only live when MEM_MISALIGN_EXC_EN is defined.
module store_align
  import common::*;
  import decode_pkg::*;
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  msize_t      size,
  input  logic [63:0] wdata,
  output logic [7:0]  strobe,
  output logic [63:0] data,
  output logic        misalign
);

  assign strobe = strobe_gen(size, addr_lo);
  assign data   = wdata << {addr_lo, 3'b000};

`ifdef MEM_MISALIGN_EXC_EN
  always_comb begin
    case (size)
      MSIZE1:  misalign = 1'b0;
      MSIZE2:  misalign = addr_lo[0];
      MSIZE4:  misalign = |addr_lo[1:0];
      default: misalign = |addr_lo;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: one load/store in flight on dbus, raw load word to writeback.
// Define MEM_MISALIGN_EXC_EN to complete misaligned accesses as exceptions without a bus request.
module mem_access_ctrl
  import common::*;
  import decode_pkg::*;
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_store,
  input  msize_t            in_msize,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [2:0]        out_addr_lo,
  output logic              out_misalign,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output msize_t            dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data
);

  mctrl_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  msize_t            size_q, size_d;
  logic              store_q, store_d;
  logic [7:0]        strobe_q, strobe_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  logic [7:0]        sa_strobe;
  logic [DATA_W-1:0] sa_data;
  logic              sa_misalign;

  store_align u_store_align (
    .addr_lo  (in_addr[2:0]),
    .size     (in_msize),
    .wdata    (in_wdata),
    .strobe   (sa_strobe),
    .data     (sa_data),
    .misalign (sa_misalign)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    store_d    = store_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          addr_d     = in_addr;
          size_d     = in_msize;
          store_d    = in_store;
          strobe_d   = in_store ? sa_strobe : 8'h00;
          wdata_d    = in_store ? sa_data : '0;
          misalign_d = sa_misalign;
          if (sa_misalign) begin
            rdata_d = '0;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A flush after the bus took the address must still wait out the data phase.
        if (flush) begin
          state_d = (dresp_addr_ok && !dresp_data_ok) ? DRAIN : IDLE;
        end else if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            rdata_d = store_q ? '0 : dresp_data;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = dresp_data_ok ? IDLE : DRAIN;
        end else if (dresp_data_ok) begin
          rdata_d = store_q ? '0 : dresp_data;
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      DRAIN: begin
        if (dresp_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= MSIZE1;
      store_q    <= 1'b0;
      strobe_q   <= 8'h00;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      store_q    <= store_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  assign in_ready     = (state_q == IDLE) && !flush && !reset;
  assign out_valid    = (state_q == DONE);
  assign out_rdata    = rdata_q;
  assign out_addr_lo  = addr_q[2:0];
  assign out_misalign = misalign_q && (state_q == DONE);
  assign dreq_valid   = (state_q == REQ);
  assign dreq_addr    = addr_q;
  assign dreq_size    = size_q;
  assign dreq_strobe  = strobe_q;
  assign dreq_data    = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (default build; misalign path when MEM_MISALIGN_EXC_EN is defined).
module tb_mem_access_ctrl;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_addr = '0;
  logic [63:0] in_wdata = '0;
  logic        in_store = 1'b0;
  msize_t      in_msize = MSIZE1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_rdata;
  logic [2:0]  out_addr_lo;
  logic        out_misalign;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  msize_t      dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;

  int vectors = 0;
  int miscompares = 0;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_store(in_store), .in_msize(in_msize),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_addr_lo(out_addr_lo), .out_misalign(out_misalign),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] a, input msize_t sz, input logic st, input logic [63:0] wd);
    in_valid = 1'b1; in_addr = a; in_msize = sz; in_store = st; in_wdata = wd;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL accept_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    vectors++;
    if ({in_ready, out_valid, dreq_valid, out_misalign} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ctrl got %b exp 0000", {in_ready, out_valid, dreq_valid, out_misalign});
    end
    vectors++;
    if ({out_rdata, dreq_addr, dreq_data, dreq_strobe} !== '0) begin
      miscompares++; $display("FAIL reset_data got %h/%h exp 0", out_rdata, dreq_addr);
    end
    @(negedge clk); reset = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_idle_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_load();
    accept(64'h8000_1000, MSIZE8, 1'b0, 64'h0);
    vectors++;
    if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_1000 || dreq_size !== MSIZE8 || dreq_strobe !== 8'h00) begin
      miscompares++; $display("FAIL ld_req got v=%b a=%h s=%0d st=%h exp 1/80001000/3/00", dreq_valid, dreq_addr, dreq_size, dreq_strobe);
    end
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    vectors++;
    if (dreq_valid !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL ld_wait got dreq_valid=%b out_valid=%b exp 0/0", dreq_valid, out_valid);
    end
    tick();
    dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_0123_4567;
    tick();
    dresp_data_ok = 1'b0; dresp_data = '0;
    vectors++;
    if (out_valid !== 1'b1 || out_rdata !== 64'hDEAD_BEEF_0123_4567 || out_addr_lo !== 3'd0 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL ld_done got v=%b d=%h lo=%0d rdy=%b exp 1/deadbeef01234567/0/0", out_valid, out_rdata, out_addr_lo, in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL ld_release got v=%b rdy=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_strobes();
    logic [2:0]  a_t[6];
    msize_t      s_t[6];
    logic [63:0] w_t[6];
    logic [7:0]  es_t[6];
    logic [63:0] ed_t[6];
    int n;
    a_t[0] = 3'd5; s_t[0] = MSIZE1; w_t[0] = 64'hAB;                es_t[0] = 8'h20; ed_t[0] = 64'h0000_AB00_0000_0000;
    a_t[1] = 3'd6; s_t[1] = MSIZE2; w_t[1] = 64'hBEEF;              es_t[1] = 8'hC0; ed_t[1] = 64'hBEEF_0000_0000_0000;
    a_t[2] = 3'd4; s_t[2] = MSIZE4; w_t[2] = 64'h1234_5678;         es_t[2] = 8'hF0; ed_t[2] = 64'h1234_5678_0000_0000;
    a_t[3] = 3'd0; s_t[3] = MSIZE8; w_t[3] = 64'h0102_0304_0506_0708; es_t[3] = 8'hFF; ed_t[3] = 64'h0102_0304_0506_0708;
    a_t[4] = 3'd6; s_t[4] = MSIZE4; w_t[4] = 64'hCAFE_F00D;         es_t[4] = 8'hC0; ed_t[4] = 64'hF00D_0000_0000_0000;
    a_t[5] = 3'd3; s_t[5] = MSIZE8; w_t[5] = 64'h1122_3344_5566_7788; es_t[5] = 8'hFF; ed_t[5] = 64'h4455_6677_8800_0000;
    n = 4;
`ifndef MEM_MISALIGN_EXC_EN
    n = 6;
`endif
    for (int i = 0; i < n; i++) begin
      accept(64'h8000_1000 | {61'd0, a_t[i]}, s_t[i], 1'b1, w_t[i]);
      vectors++;
      if (dreq_valid !== 1'b1 || dreq_strobe !== es_t[i] || dreq_data !== ed_t[i]) begin
        miscompares++; $display("FAIL st_lanes[%0d] got v=%b st=%h d=%h exp 1/%h/%h", i, dreq_valid, dreq_strobe, dreq_data, es_t[i], ed_t[i]);
      end
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h5555_AAAA_5555_AAAA;
      tick();
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
      vectors++;
      if (out_valid !== 1'b1 || out_rdata !== 64'h0 || out_addr_lo !== a_t[i] || out_misalign !== 1'b0) begin
        miscompares++; $display("FAIL st_done[%0d] got v=%b d=%h lo=%0d m=%b exp 1/0/%0d/0", i, out_valid, out_rdata, out_addr_lo, out_misalign, a_t[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    accept(64'h8000_2003, MSIZE1, 1'b0, 64'h0);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h0123_4567_89AB_CDEF;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_rdata !== 64'h0123_4567_89AB_CDEF || in_ready !== 1'b0 || out_addr_lo !== 3'd3) begin
        miscompares++; $display("FAIL bp_hold[%0d] got v=%b d=%h rdy=%b lo=%0d exp 1/0123456789abcdef/0/3", i, out_valid, out_rdata, in_ready, out_addr_lo);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release got v=%b rdy=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      accept(64'h8000_3000 + 64'(i * 8), MSIZE8, 1'b0, 64'h0);
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h1000 + 64'(i);
      tick();
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_rdata !== 64'h1000 + 64'(i)) begin
        miscompares++; $display("FAIL b2b[%0d] got v=%b d=%h exp 1/%h", i, out_valid, out_rdata, 64'h1000 + 64'(i));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_flush_wait();
    accept(64'h8000_4000, MSIZE8, 1'b0, 64'h0);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || dreq_valid !== 1'b0) begin
        miscompares++; $display("FAIL drain_hold[%0d] got rdy=%b v=%b dreq=%b exp 0/0/0", i, in_ready, out_valid, dreq_valid);
      end
      tick();
    end
    dresp_data_ok = 1'b1; dresp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL drain_dataok_ready got %b exp 0", in_ready); end
    tick();
    dresp_data_ok = 1'b0; dresp_data = '0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL drain_exit got rdy=%b v=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush_req();
    accept(64'h8000_5000, MSIZE4, 1'b0, 64'h0);
    vectors++;
    if (dreq_valid !== 1'b1) begin miscompares++; $display("FAIL fr_req got %b exp 1", dreq_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    vectors++;
    if (dreq_valid !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL fr_idle got dreq=%b rdy=%b v=%b exp 0/1/0", dreq_valid, in_ready, out_valid);
    end
  endtask

  task automatic test_flush_done();
    accept(64'h8000_6000, MSIZE8, 1'b0, 64'h0);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h77;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL fd_discard got v=%b rdy=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_EXC_EN
    accept(64'h8000_1003, MSIZE2, 1'b0, 64'h0);
    vectors++;
    if (dreq_valid !== 1'b0 || out_valid !== 1'b1 || out_misalign !== 1'b1 || out_rdata !== 64'h0) begin
      miscompares++; $display("FAIL misalign got dreq=%b v=%b m=%b d=%h exp 0/1/1/0", dreq_valid, out_valid, out_misalign, out_rdata);
    end
`else
    accept(64'h8000_1003, MSIZE2, 1'b0, 64'h0);
    vectors++;
    if (dreq_valid !== 1'b1 || dreq_strobe !== 8'h00) begin
      miscompares++; $display("FAIL misalign_issued got dreq=%b st=%h exp 1/00", dreq_valid, dreq_strobe);
    end
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h42;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_misalign !== 1'b0 || out_rdata !== 64'h42) begin
      miscompares++; $display("FAIL misalign_off got v=%b m=%b d=%h exp 1/0/42", out_valid, out_misalign, out_rdata);
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    accept(64'h8000_7008, MSIZE8, 1'b0, 64'h0);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, dreq_valid} !== 3'b000 || dreq_addr !== 64'h0 || out_addr_lo !== 3'd0) begin
      miscompares++; $display("FAIL rst_async got ctrl=%b a=%h exp 000/0", {in_ready, out_valid, dreq_valid}, dreq_addr);
    end
    tick();
    @(negedge clk); reset = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || dreq_valid !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_release got rdy=%b dreq=%b v=%b exp 1/0/0", in_ready, dreq_valid, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_strobes();
    test_backpressure();
    test_back_to_back();
    test_flush_wait();
    test_flush_req();
    test_flush_done();
    test_misalign();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
